// File: rtl/bnn_pkg.sv
// Widths and constants shared between the XNOR-popcount FC stage and the argmax classifier.
package bnn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 10;
  localparam int BIAS_W      = 8;
  localparam int IDX_W       = 4;
  localparam int ADJ_W       = SCORE_W + 2;

  localparam logic signed [ADJ_W-1:0] ADJ_MIN = {1'b1, {(ADJ_W-1){1'b0}}};

endpackage

// File: rtl/bnn_top2_tracker.sv
// Stage B: running best / runner-up tracker over the bias-adjusted class scores of one frame.
module bnn_top2_tracker
  import bnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic signed [ADJ_W-1:0] i_adj,
  input  logic        [IDX_W-1:0] i_idx,
  output logic signed [ADJ_W-1:0] o_best,
  output logic signed [ADJ_W-1:0] o_second,
  output logic        [IDX_W-1:0] o_best_idx
);

  logic signed [ADJ_W-1:0] r_best;
  logic signed [ADJ_W-1:0] r_second;
  logic        [IDX_W-1:0] r_best_idx;

  // Strict compare keeps the lower index on ties; the tie still lands in second, giving margin 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best     <= '0;
      r_second   <= '0;
      r_best_idx <= '0;
    end else if (i_valid) begin
      if (i_first) begin
        r_best     <= i_adj;
        r_best_idx <= '0;
        r_second   <= ADJ_MIN;
      end else if (i_adj > r_best) begin
        r_second   <= r_best;
        r_best     <= i_adj;
        r_best_idx <= i_idx;
      end else if (i_adj > r_second) begin
        r_second   <= i_adj;
      end
    end
  end

  assign o_best     = r_best;
  assign o_second   = r_second;
  assign o_best_idx = r_best_idx;

endmodule

// File: rtl/bnn_argmax_classifier.sv
// Bias-adjusted argmax over the FC-stage popcounts; one result pulse per frame of NUM_CLASSES beats.
module bnn_argmax_classifier
  import bnn_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic                          i_valid,
  input  logic [SCORE_W-1:0]            i_score,
  input  logic [NUM_CLASSES*BIAS_W-1:0] i_bias,
  output logic                          o_valid,
  output logic [IDX_W-1:0]              o_class,
  output logic [ADJ_W-1:0]              o_score,
  output logic [ADJ_W-1:0]              o_margin,
  output logic                          o_busy
);

  logic [BIAS_W-1:0]       w_bias_arr [NUM_CLASSES];
  logic [BIAS_W-1:0]       w_bias;
  logic signed [ADJ_W-1:0] w_adj;
  logic                    w_last;

  logic [IDX_W-1:0]        r_idx;
  logic signed [ADJ_W-1:0] r_a_adj;
  logic [IDX_W-1:0]        r_a_idx;
  logic                    r_a_last;
  logic                    r_a_valid;
  logic                    r_done;

  logic signed [ADJ_W-1:0] w_best;
  logic signed [ADJ_W-1:0] w_second;
  logic [IDX_W-1:0]        w_best_idx;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_bias
    assign w_bias_arr[k] = i_bias[k*BIAS_W +: BIAS_W];
  end

  assign w_bias = w_bias_arr[r_idx];
  assign w_adj  = $signed({{(ADJ_W-SCORE_W){1'b0}}, i_score})
                + $signed({{(ADJ_W-BIAS_W){w_bias[BIAS_W-1]}}, w_bias});
  assign w_last = (r_idx == IDX_W'(NUM_CLASSES-1));

  // Stage A: class counter and bias add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_a_adj   <= '0;
      r_a_idx   <= '0;
      r_a_last  <= 1'b0;
      r_a_valid <= 1'b0;
    end else if (i_clear) begin
      r_idx     <= '0;
      r_a_valid <= 1'b0;
    end else if (i_valid) begin
      r_idx     <= w_last ? '0 : r_idx + 1'b1;
      r_a_adj   <= w_adj;
      r_a_idx   <= r_idx;
      r_a_last  <= w_last;
      r_a_valid <= 1'b1;
    end else begin
      r_a_valid <= 1'b0;
    end
  end

  // A clear in the same cycle as a stage-A beat must not disturb best/second.
  bnn_top2_tracker u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (r_a_valid & ~i_clear),
    .i_first    (r_a_idx == '0),
    .i_adj      (r_a_adj),
    .i_idx      (r_a_idx),
    .o_best     (w_best),
    .o_second   (w_second),
    .o_best_idx (w_best_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else if (i_clear) begin
      r_done <= 1'b0;
    end else begin
      r_done <= r_a_valid & r_a_last;
    end
  end

  // Output stage ignores i_clear so a result already in flight still completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_class  <= '0;
      o_score  <= '0;
      o_margin <= '0;
    end else begin
      o_valid <= r_done;
      if (r_done) begin
        o_class  <= w_best_idx;
        o_score  <= w_best;
        o_margin <= w_best - w_second;
      end
    end
  end

  assign o_busy = (r_idx != '0) | r_a_valid | r_done;

endmodule

// File: tb/tb_bnn_argmax_classifier.sv
// Directed bench for bnn_argmax_classifier: fixed frames with hand-derived results plus a random back-to-back pair.
module tb_bnn_argmax_classifier;
  import bnn_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          i_clear;
  logic                          i_valid;
  logic [SCORE_W-1:0]            i_score;
  logic [NUM_CLASSES*BIAS_W-1:0] i_bias;
  logic                          o_valid;
  logic [IDX_W-1:0]              o_class;
  logic [ADJ_W-1:0]              o_score;
  logic [ADJ_W-1:0]              o_margin;
  logic                          o_busy;

  bnn_argmax_classifier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_clear),
    .i_valid  (i_valid),
    .i_score  (i_score),
    .i_bias   (i_bias),
    .o_valid  (o_valid),
    .o_class  (o_class),
    .o_score  (o_score),
    .o_margin (o_margin),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    time              t;
    logic [IDX_W-1:0] cls;
    logic [ADJ_W-1:0] score;
    logic [ADJ_W-1:0] margin;
  } res_t;

  res_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  time  t_last;
  int   sc [NUM_CLASSES];
  int   bs [NUM_CLASSES];

  always @(negedge clk)
    if (rst_n && o_valid) q.push_back('{$time, o_class, o_score, o_margin});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_bias();
    for (int k = 0; k < NUM_CLASSES; k++) i_bias[k*BIAS_W +: BIAS_W] = BIAS_W'(bs[k]);
  endtask

  task automatic beat(input int s);
    @(negedge clk);
    i_valid = 1'b1;
    i_clear = 1'b0;
    i_score = SCORE_W'(s);
    t_last  = $time;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_clear = 1'b0;
    end
  endtask

  task automatic send_frame();
    for (int k = 0; k < NUM_CLASSES; k++) beat(sc[k]);
  endtask

  // Frame result: first maximum wins; margin against the largest of all other classes.
  task automatic ref_frame(output int cls, output int best, output int margin);
    int adj [NUM_CLASSES];
    int run;
    for (int k = 0; k < NUM_CLASSES; k++) adj[k] = sc[k] + bs[k];
    cls = 0;
    for (int k = 1; k < NUM_CLASSES; k++) if (adj[k] > adj[cls]) cls = k;
    best = adj[cls];
    run  = -100000;
    for (int k = 0; k < NUM_CLASSES; k++) if (k != cls && adj[k] > run) run = adj[k];
    margin = best - run;
  endtask

  task automatic chk_res(input string tag, input res_t r, input int cls, input int score, input int margin);
    logic [ADJ_W-1:0] e_s;
    logic [ADJ_W-1:0] e_m;
    e_s = ADJ_W'(score);
    e_m = ADJ_W'(margin);
    chk({tag, "_class"},  32'(r.cls),    32'(cls));
    chk({tag, "_score"},  32'(r.score),  32'(e_s));
    chk({tag, "_margin"}, 32'(r.margin), 32'(e_m));
  endtask

  task automatic expect_one(input string tag, input int cls, input int score, input int margin);
    res_t r;
    chk({tag, "_count"}, 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      r = q.pop_front();
      chk({tag, "_latency"}, 32'(r.t - t_last), 32'd30);
      chk_res(tag, r, cls, score, margin);
    end
    q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"},  32'(o_valid),  32'd0);
    chk({tag, "_class"},  32'(o_class),  32'd0);
    chk({tag, "_score"},  32'(o_score),  32'd0);
    chk({tag, "_margin"}, 32'(o_margin), 32'd0);
    chk({tag, "_busy"},   32'(o_busy),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   c1, s1, m1, c2, s2, m2;
    res_t ra, rb;
    rst_n   = 1'b0;
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_score = '0;
    i_bias  = '0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Plain argmax with zero biases
    bs = '{default: 0};
    apply_bias();
    sc = '{10, 20, 30, 40, 250, 60, 70, 80, 90, 100};
    send_frame();
    idle(6);
    expect_one("basic", 4, 250, 150);

    // All tied, then a single class one above the rest
    sc = '{default: 128};
    send_frame();
    idle(6);
    expect_one("tie", 0, 128, 0);
    sc[3] = 129;
    send_frame();
    idle(6);
    expect_one("tie_break", 3, 129, 1);

    // Signed biases
    bs = '{default: 0};
    bs[7] = 5;
    bs[2] = -128;
    apply_bias();
    sc = '{default: 100};
    send_frame();
    idle(6);
    expect_one("bias_pos", 7, 105, 5);
    bs = '{default: 0};
    bs[0] = -128;
    apply_bias();
    sc = '{default: 0};
    send_frame();
    idle(6);
    expect_one("bias_neg", 1, 0, 0);

    // Two random frames back to back, same biases
    for (int k = 0; k < NUM_CLASSES; k++) bs[k] = int'($urandom_range(0, 255)) - 128;
    apply_bias();
    for (int k = 0; k < NUM_CLASSES; k++) sc[k] = int'($urandom_range(0, 256));
    ref_frame(c1, s1, m1);
    send_frame();
    for (int k = 0; k < NUM_CLASSES; k++) sc[k] = int'($urandom_range(0, 256));
    ref_frame(c2, s2, m2);
    send_frame();
    idle(6);
    chk("b2b_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      ra = q.pop_front();
      rb = q.pop_front();
      chk("b2b_spacing", 32'(rb.t - ra.t), 32'(NUM_CLASSES * 10));
      chk("b2b_latency", 32'(rb.t - t_last), 32'd30);
      chk_res("b2b_f0", ra, c1, s1, m1);
      chk_res("b2b_f1", rb, c2, s2, m2);
    end
    q.delete();

    // Partial frame with gaps, clear with a simultaneous beat, then a full frame
    bs = '{default: 0};
    apply_bias();
    beat(40);  idle(1);
    beat(255); idle(1);
    beat(30);  idle(2);
    beat(20);  idle(1);
    beat(10);
    @(negedge clk);
    i_valid = 1'b1;
    i_clear = 1'b1;
    i_score = SCORE_W'(77);
    @(negedge clk);
    chk("clear_busy", 32'(o_busy), 32'd0);
    i_valid = 1'b0;
    i_clear = 1'b0;
    idle(3);
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 200};
    send_frame();
    idle(6);
    expect_one("clear", 9, 200, 191);

    // Asynchronous reset in the middle of a frame
    sc = '{200, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    for (int k = 0; k < 6; k++) beat(sc[k]);
    #2 rst_n = 1'b0;
    i_valid = 1'b0;
    #1 chk_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    sc = '{12, 50, 3, 4, 5, 6, 7, 8, 9, 49};
    send_frame();
    idle(6);
    expect_one("post_reset", 1, 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
